lpc_io_host: RTL and testbench

- LPC host-side initiator for 8-bit I/O read/write cycles; the transmitting end of the same LPC I/O protocol that the CPLD register decoder receives.
- Used by board test logic and the BMC-bridge path to reach LPC peripherals, and as a loopback stimulus source for the CPLD decoder.
- Accepts a single-entry request, serialises START/CYCTYPE/ADDR/DATA/TAR, and tracks peripheral SYNC including wait states, error SYNC and timeout abort.

---
 rtl/lpc_io_host.sv | 143 ++++++++++++++
 tb/tb_lpc_io_host.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_host.sv
// lpc_io_host: LPC host initiator for 8-bit I/O read/write cycles with SYNC wait, error and timeout handling.
module lpc_io_host #(
  parameter int unsigned NOSYNC_LIMIT = 3,
  parameter int unsigned WAIT_LIMIT   = 255
) (
  input  logic        PciReset,
  input  logic        LpcClock,
  input  logic        Req,
  input  logic        ReqWr,
  input  logic [15:0] ReqAddr,
  input  logic [7:0]  ReqWrData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  RdData,
  output logic        LpcFrameN,
  output logic [3:0]  LadOut,
  output logic        LadOe,
  input  logic [3:0]  LadIn
);
  localparam logic [4:0] S_IDLE  = 5'd0;
  localparam logic [4:0] S_START = 5'd1;
  localparam logic [4:0] S_CYC   = 5'd2;
  localparam logic [4:0] S_A3    = 5'd3;
  localparam logic [4:0] S_A2    = 5'd4;
  localparam logic [4:0] S_A1    = 5'd5;
  localparam logic [4:0] S_A0    = 5'd6;
  localparam logic [4:0] S_D0    = 5'd7;
  localparam logic [4:0] S_D1    = 5'd8;
  localparam logic [4:0] S_HTAR0 = 5'd9;
  localparam logic [4:0] S_HTAR1 = 5'd10;
  localparam logic [4:0] S_SYNC  = 5'd11;
  localparam logic [4:0] S_RD0   = 5'd12;
  localparam logic [4:0] S_RD1   = 5'd13;
  localparam logic [4:0] S_PTAR0 = 5'd14;
  localparam logic [4:0] S_PTAR1 = 5'd15;
  localparam logic [4:0] S_ABORT = 5'd16;
  localparam logic [4:0] S_FIN   = 5'd17;
  localparam logic [3:0] L_NOSYNC = NOSYNC_LIMIT[3:0];
  localparam logic [7:0] L_WAIT   = WAIT_LIMIT[7:0];
  logic [4:0]  r_state;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [3:0]  r_nosync;
  logic [7:0]  r_wait;
  logic [1:0]  r_abort;
  logic [4:0]  w_nstate;
  logic [3:0]  w_lad;
  logic [3:0]  w_nosync_inc;
  logic [7:0]  w_wait_inc;
  logic        w_is_ok;
  logic        w_is_wait;
  assign w_nosync_inc = r_nosync + 4'd1;
  assign w_wait_inc   = r_wait + 8'd1;
  assign w_is_ok      = (LadIn == 4'h0) || (LadIn == 4'hA);
  assign w_is_wait    = (LadIn == 4'h5) || (LadIn == 4'h6);
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  w_nstate = Req ? S_START : S_IDLE;
      S_START: w_nstate = S_CYC;
      S_CYC:   w_nstate = S_A3;
      S_A3:    w_nstate = S_A2;
      S_A2:    w_nstate = S_A1;
      S_A1:    w_nstate = S_A0;
      S_A0:    w_nstate = r_wr ? S_D0 : S_HTAR0;
      S_D0:    w_nstate = S_D1;
      S_D1:    w_nstate = S_HTAR0;
      S_HTAR0: w_nstate = S_HTAR1;
      S_HTAR1: w_nstate = S_SYNC;
      S_SYNC:  w_nstate = w_is_ok ? (r_wr ? S_PTAR0 : S_RD0) :
                          w_is_wait ? ((w_wait_inc == L_WAIT) ? S_ABORT : S_SYNC) :
                          ((w_nosync_inc == L_NOSYNC) ? S_ABORT : S_SYNC);
      S_RD0:   w_nstate = S_RD1;
      S_RD1:   w_nstate = S_PTAR0;
      S_PTAR0: w_nstate = S_PTAR1;
      S_PTAR1: w_nstate = S_FIN;
      S_ABORT: w_nstate = (r_abort == 2'd3) ? S_FIN : S_ABORT;
      default: w_nstate = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so each value appears during its state.
  always_comb begin
    w_lad = 4'hF;
    case (w_nstate)
      S_START: w_lad = 4'h0;
      S_CYC:   w_lad = {2'b00, r_wr, 1'b0};
      S_A3:    w_lad = r_addr[15:12];
      S_A2:    w_lad = r_addr[11:8];
      S_A1:    w_lad = r_addr[7:4];
      S_A0:    w_lad = r_addr[3:0];
      S_D0:    w_lad = r_wdata[3:0];
      S_D1:    w_lad = r_wdata[7:4];
      default: w_lad = 4'hF;
    endcase
  end
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_nosync  <= 4'd0;
      r_wait    <= 8'd0;
      r_abort   <= 2'd0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      RdData    <= 8'h00;
      LpcFrameN <= 1'b1;
      LadOut    <= 4'hF;
      LadOe     <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      LpcFrameN <= !((w_nstate == S_START) || (w_nstate == S_ABORT));
      LadOe     <= ((w_nstate >= S_START) && (w_nstate <= S_HTAR0)) || (w_nstate == S_ABORT);
      LadOut    <= w_lad;
      Done      <= (w_nstate == S_FIN);
      r_abort   <= (r_state == S_ABORT) ? r_abort + 2'd1 : 2'd0;
      if ((r_state == S_IDLE) && Req) begin
        r_wr    <= ReqWr;
        r_addr  <= ReqAddr;
        r_wdata <= ReqWrData;
        Error   <= 1'b0;
        Busy    <= 1'b1;
      end
      if (w_nstate == S_FIN) Busy <= 1'b0;
      if (((r_state == S_SYNC) && (LadIn == 4'hA)) || (w_nstate == S_ABORT)) Error <= 1'b1;
      if (r_state == S_RD0) RdData[3:0] <= LadIn;
      if (r_state == S_RD1) RdData[7:4] <= LadIn;
      if (r_state != S_SYNC) begin
        r_nosync <= 4'd0;
        r_wait   <= 8'd0;
      end else if (w_is_wait) begin
        r_wait   <= w_wait_inc;
        r_nosync <= 4'd0;
      end else if (!w_is_ok) begin
        r_nosync <= w_nosync_inc;
      end
    end
  end
endmodule

// File: tb/tb_lpc_io_host.sv
// tb_lpc_io_host: directed and random LPC I/O cycles checked against a per-cycle bus model built from the protocol rules.
module tb_lpc_io_host;
  localparam int NSL = 3;
  localparam int WL  = 8;
  logic        PciReset = 1'b0;
  logic        LpcClock = 1'b0;
  logic        Req = 1'b0;
  logic        ReqWr = 1'b0;
  logic [15:0] ReqAddr = 16'h0000;
  logic [7:0]  ReqWrData = 8'h00;
  logic        Busy, Done, Error, LpcFrameN, LadOe;
  logic [7:0]  RdData;
  logic [3:0]  LadOut;
  logic [3:0]  LadIn = 4'hF;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  m_rd = 8'h00;
  logic        m_err = 1'b0;
  logic [3:0]  sync_q[$];
  logic [3:0]  sync_fill = 4'h0;
  bit          e_frame[$];
  bit          e_oe[$];
  logic [3:0]  e_lad[$];
  logic [3:0]  e_drv[$];

  always #15 LpcClock = ~LpcClock;

  lpc_io_host #(.NOSYNC_LIMIT(NSL), .WAIT_LIMIT(WL)) dut (
    .PciReset(PciReset), .LpcClock(LpcClock), .Req(Req), .ReqWr(ReqWr),
    .ReqAddr(ReqAddr), .ReqWrData(ReqWrData), .Busy(Busy), .Done(Done),
    .Error(Error), .RdData(RdData), .LpcFrameN(LpcFrameN), .LadOut(LadOut),
    .LadOe(LadOe), .LadIn(LadIn)
  );

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic push(bit f, bit oe, logic [3:0] lad, logic [3:0] drv);
    e_frame.push_back(f);
    e_oe.push_back(oe);
    e_lad.push_back(lad);
    e_drv.push_back(drv);
  endtask

  // Expected bus cycles from START onward; the peripheral's SYNC answers come from sync_q then sync_fill.
  task automatic build(bit wr, logic [15:0] a, logic [7:0] d, logic [3:0] rlo, logic [3:0] rhi);
    int waits = 0;
    int ns = 0;
    bit fin = 0;
    bit ab = 0;
    bit er = 0;
    logic [3:0] s;
    e_frame.delete(); e_oe.delete(); e_lad.delete(); e_drv.delete();
    push(0, 1, 4'h0, 4'hF);
    push(1, 1, wr ? 4'h2 : 4'h0, 4'hF);
    for (int i = 3; i >= 0; i--) push(1, 1, a[i*4 +: 4], 4'hF);
    if (wr) begin
      push(1, 1, d[3:0], 4'hF);
      push(1, 1, d[7:4], 4'hF);
    end
    push(1, 1, 4'hF, 4'hF);
    push(1, 0, 4'hF, 4'hF);
    while (!fin) begin
      s = (sync_q.size() > 0) ? sync_q.pop_front() : sync_fill;
      push(1, 0, 4'hF, s);
      if (s == 4'h0 || s == 4'hA) begin
        fin = 1;
        er = (s == 4'hA);
      end else if (s == 4'h5 || s == 4'h6) begin
        waits++;
        ns = 0;
        if (waits == WL) begin fin = 1; ab = 1; end
      end else begin
        ns++;
        if (ns == NSL) begin fin = 1; ab = 1; end
      end
    end
    sync_q.delete();
    if (ab) begin
      repeat (4) push(0, 1, 4'hF, 4'hF);
      m_err = 1'b1;
    end else begin
      m_err = er;
      if (!wr) begin
        push(1, 0, 4'hF, rlo);
        push(1, 0, 4'hF, rhi);
        m_rd = {rhi, rlo};
      end
      push(1, 0, 4'hF, 4'hF);
      push(1, 0, 4'hF, 4'hF);
    end
  endtask

  task automatic run(bit wr, logic [15:0] a, logic [7:0] d, logic [3:0] rlo, logic [3:0] rhi, bit hold, bit poke);
    build(wr, a, d, rlo, rhi);
    @(negedge LpcClock);
    Req = 1'b1; ReqWr = wr; ReqAddr = a; ReqWrData = d;
    @(posedge LpcClock); #1;
    if (!hold) Req = 1'b0;
    for (int k = 0; k < e_frame.size(); k++) begin
      chk("frame", 8'(LpcFrameN), 8'(e_frame[k]));
      chk("lad_oe", 8'(LadOe), 8'(e_oe[k]));
      if (e_oe[k]) chk("lad_out", 8'(LadOut), 8'(e_lad[k]));
      chk("busy_run", 8'(Busy), 8'd1);
      chk("done_early", 8'(Done), 8'd0);
      LadIn = e_drv[k];
      if (poke) Req = (k == 5);
      @(posedge LpcClock); #1;
    end
    LadIn = 4'hF;
    chk("done_fin", 8'(Done), 8'd1);
    chk("busy_fin", 8'(Busy), 8'd0);
    chk("error", 8'(Error), 8'(m_err));
    chk("rddata", RdData, m_rd);
    @(posedge LpcClock); #1;
    chk("idle_done", 8'(Done), 8'd0);
    chk("idle_busy", 8'(Busy), 8'd0);
    chk("idle_frame", 8'(LpcFrameN), 8'd1);
    chk("idle_oe", 8'(LadOe), 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] tbl [7];
    logic [3:0] fills [4];
    tbl   = '{4'h0, 4'hA, 4'h5, 4'h6, 4'hF, 4'h3, 4'hC};
    fills = '{4'h0, 4'hA, 4'hF, 4'h5};
    repeat (2) @(posedge LpcClock);
    #1;
    chk("rst_frame", 8'(LpcFrameN), 8'd1);
    chk("rst_oe", 8'(LadOe), 8'd0);
    chk("rst_lad", 8'(LadOut), 8'h0F);
    chk("rst_busy", 8'(Busy), 8'd0);
    chk("rst_done", 8'(Done), 8'd0);
    chk("rst_error", 8'(Error), 8'd0);
    chk("rst_rddata", RdData, 8'h00);
    @(negedge LpcClock); PciReset = 1'b1;
    sync_q = '{4'h0};
    run(1, 16'h0080, 8'hA5, 4'hF, 4'hF, 0, 0);
    sync_q = '{4'h6, 4'h6, 4'h0};
    run(0, 16'h0084, 8'h00, 4'h3, 4'hC, 0, 0);
    sync_q = '{4'hA};
    run(0, 16'h1234, 8'h00, 4'hF, 4'hF, 0, 0);
    sync_fill = 4'hF;
    run(0, 16'h5678, 8'h00, 4'h1, 4'h2, 0, 0);
    sync_fill = 4'h5;
    run(1, 16'h9ABC, 8'h3C, 4'hF, 4'hF, 0, 0);
    sync_fill = 4'h0;
    // Reset dropped in the middle of A1 of a write.
    @(negedge LpcClock);
    Req = 1'b1; ReqWr = 1'b1; ReqAddr = 16'hBEEF; ReqWrData = 8'h77;
    @(posedge LpcClock); #1;
    Req = 1'b0;
    repeat (4) @(posedge LpcClock);
    #5;
    chk("a1_oe", 8'(LadOe), 8'd1);
    chk("a1_lad", 8'(LadOut), 8'h0E);
    PciReset = 1'b0;
    #1;
    m_err = 1'b0;
    m_rd = 8'h00;
    chk("arst_frame", 8'(LpcFrameN), 8'd1);
    chk("arst_oe", 8'(LadOe), 8'd0);
    chk("arst_busy", 8'(Busy), 8'd0);
    chk("arst_lad", 8'(LadOut), 8'h0F);
    chk("arst_error", 8'(Error), 8'd0);
    chk("arst_rddata", RdData, 8'h00);
    @(negedge LpcClock); PciReset = 1'b1;
    sync_q = '{4'h0};
    run(1, 16'hBEEF, 8'h77, 4'hF, 4'hF, 0, 0);
    sync_q = '{4'h5, 4'h0};
    run(0, 16'h0060, 8'h00, 4'h9, 4'h6, 0, 1);
    repeat (3) begin
      @(posedge LpcClock); #1;
      chk("poke_busy", 8'(Busy), 8'd0);
      chk("poke_frame", 8'(LpcFrameN), 8'd1);
    end
    sync_q = '{4'h0};
    run(1, 16'h0070, 8'h11, 4'hF, 4'hF, 1, 0);
    sync_q = '{4'h6, 4'h0};
    run(0, 16'h0071, 8'h00, 4'hD, 4'h4, 0, 0);
    for (int t = 0; t < 20; t++) begin
      int len;
      len = $urandom_range(0, 3);
      for (int j = 0; j < len; j++) sync_q.push_back(tbl[$urandom_range(0, 6)]);
      sync_fill = fills[$urandom_range(0, 3)];
      run(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
